ram_avalon_bridge: RTL and testbench
====================================

Name: ram_avalon_bridge

Overview:
- Avalon-MM slave that gives the HPS-side initiator word access to the 64x8 single-port FPGA RAM.
- Drives the RAM's addr/we/data pins and samples its q output.
- Also runs a hardware clear sweep, so the annealer state RAM can be initialised without HPS traffic.
- Sits between the HPS bus fabric and the fpga_addr/fpga_we/fpga_data/fpga_q RAM port.

Parameters:
ADDR_W, 6, RAM address width; word count is 2**ADDR_W.
DATA_W, 8, RAM and Avalon data width.

Ports:
clk  input  1  system clock, 50 MHz; all logic on its rising edge
reset  input  1  synchronous, active-high reset
avs_address  input  ADDR_W  Avalon word address
avs_read  input  1  read request
avs_write  input  1  write request
avs_writedata  input  DATA_W  write data
avs_waitrequest  output  1  high = request not accepted this cycle (combinational)
avs_readdata  output  DATA_W  read data, valid with avs_readdatavalid
avs_readdatavalid  output  1  one-cycle pulse per accepted read
clear_start  input  1  pulse: fill entire RAM with fill_value
fill_value  input  DATA_W  value written during the clear sweep, sampled at clear_start acceptance
busy  output  1  high whenever state != IDLE
clear_done  output  1  one-cycle pulse when the sweep completes
ram_addr  output  ADDR_W  RAM address (registered)
ram_we  output  1  RAM write enable (registered)
ram_data  output  DATA_W  RAM write data (registered)
ram_q  input  DATA_W  RAM read data; valid one clk after ram_addr is presented

Behaviour:
- Reset values: ram_addr=0, ram_we=0, ram_data=0, avs_readdata=0, avs_readdatavalid=0, clear_done=0, busy=0, state=IDLE.
- Reset mid-operation:
  - Any read or clear in flight is abandoned and no readdatavalid is issued.
  - ram_we is 0 on the cycle after the reset edge.
- avs_waitrequest = (state != IDLE) | clear_start | reset.
- A request is accepted only when avs_read or avs_write is high and avs_waitrequest is low.
- States: IDLE, WR, RD_ADDR, RD_DATA, CLEAR.
- IDLE:
  - Priority order: clear_start > avs_write > avs_read.
  - Both avs_read and avs_write high: write is accepted, read is dropped (initiator must re-issue it).
  - clear_start: latch fill_value, set sweep counter to 0, go to CLEAR.
  - Write accepted: register ram_addr=avs_address, ram_data=avs_writedata, ram_we=1; go to WR.
  - Read accepted: register ram_addr=avs_address, ram_we=0; go to RD_ADDR.
- WR: ram_we=1 for exactly this one cycle (RAM commits at the end of WR); next state IDLE with ram_we=0.
- RD_ADDR: RAM latches the address; next state RD_DATA.
- RD_DATA: ram_q is valid; register avs_readdata=ram_q and set avs_readdatavalid=1 for the following cycle; next state IDLE.
- Read latency: accepted at cycle T, avs_readdatavalid high at T+3 for exactly one cycle.
- Back-to-back reads are accepted no faster than one per 3 cycles.
- avs_readdata holds its value until the next read completes.
- Write cost: accepted at T, RAM updated at the end of T+1, next request accepted at T+2 at the earliest.
- CLEAR:
  - Each cycle: ram_we=1, ram_addr=counter, ram_data=latched fill_value.
  - Counter increments 0 to 2**ADDR_W-1 with no wrap; after the last address, ram_we=0, clear_done pulses 1 cycle, state returns to IDLE.
  - Sweep takes exactly 2**ADDR_W write cycles.
  - clear_start asserted while busy is ignored.
  - Avalon requests stay stalled for the whole sweep.
- busy and avs_waitrequest are both high throughout WR, RD_ADDR, RD_DATA and CLEAR.
- ram_we is never high outside WR and CLEAR.

Test Plan:
- Write 0xA5 to addr 5 (with reset deasserted), then read addr 5 -> waitrequest low on acceptance, ram_we high for one cycle with ram_addr=5 and ram_data=0xA5, readdatavalid at T+3 with readdata=0xA5.
- Write addr 0=0x11 and addr 63=0x3F, then read 63 and read 0 back-to-back -> readdata 0x3F then 0x11, readdatavalid pulses 3 cycles apart, no extra pulses.
- clear_start with fill_value=0x00 after writing nonzero data -> exactly 64 consecutive ram_we cycles on addresses 0..63 with data 0; a read issued during the sweep is held by waitrequest; clear_done pulses once; every readback afterwards returns 0x00.
- clear_start and avs_write in the same IDLE cycle -> write not accepted (waitrequest high), clear runs; after clear_done the held write is accepted and read back correctly.
- avs_read and avs_write both high, addr 7, data 0x5A -> write performed, no readdatavalid; a subsequent read of 7 returns 0x5A.
- reset pulsed during RD_ADDR, and separately at clear counter=20 -> no readdatavalid or clear_done; ram_we=0 the cycle after reset; state IDLE with waitrequest low once reset deasserts.

Source files
------------

// File: rtl/ram_avalon_bridge.sv
// Avalon-MM slave giving word access to a 64x8 single-port RAM,
// plus a hardware sweep that fills the whole RAM with one value.
module ram_avalon_bridge #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] cnt_r, cnt_next_s;
    logic [DATA_W-1:0] fill_r, fill_next_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_next_s;
    logic              ram_we_r, ram_we_next_s;
    logic [DATA_W-1:0] ram_data_r, ram_data_next_s;
    logic [DATA_W-1:0] readdata_r, readdata_next_s;
    logic              rdvalid_r, rdvalid_next_s;
    logic              done_r, done_next_s;

    assign avs_waitrequest   = (state_r != IDLE) | clear_start | reset;
    assign busy              = (state_r != IDLE);
    assign avs_readdata      = readdata_r;
    assign avs_readdatavalid = rdvalid_r;
    assign clear_done        = done_r;
    assign ram_addr          = ram_addr_r;
    assign ram_we            = ram_we_r;
    assign ram_data          = ram_data_r;

    // State and registered outputs; reset abandons any read or sweep in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            fill_r     <= '0;
            ram_addr_r <= '0;
            ram_we_r   <= 1'b0;
            ram_data_r <= '0;
            readdata_r <= '0;
            rdvalid_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            fill_r     <= fill_next_s;
            ram_addr_r <= ram_addr_next_s;
            ram_we_r   <= ram_we_next_s;
            ram_data_r <= ram_data_next_s;
            readdata_r <= readdata_next_s;
            rdvalid_r  <= rdvalid_next_s;
            done_r     <= done_next_s;
        end
    end

    // Next-state selection; in IDLE a clear beats a write, which beats a read
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (clear_start) begin
                    state_next_s = CLEAR;
                end else if (avs_write) begin
                    state_next_s = WR;
                end else if (avs_read) begin
                    state_next_s = RD_ADDR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR:      state_next_s = IDLE;
            RD_ADDR: state_next_s = RD_DATA;
            RD_DATA: state_next_s = IDLE;
            CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered RAM-side and Avalon-side outputs
    always_comb begin
        cnt_next_s      = cnt_r;
        fill_next_s     = fill_r;
        ram_addr_next_s = ram_addr_r;
        ram_we_next_s   = 1'b0;
        ram_data_next_s = ram_data_r;
        readdata_next_s = readdata_r;
        rdvalid_next_s  = 1'b0;
        done_next_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear_start) begin
                    fill_next_s     = fill_value;
                    cnt_next_s      = '0;
                    ram_addr_next_s = '0;
                    ram_data_next_s = fill_value;
                    ram_we_next_s   = 1'b1;
                end else if (avs_write) begin
                    ram_addr_next_s = avs_address;
                    ram_data_next_s = avs_writedata;
                    ram_we_next_s   = 1'b1;
                end else if (avs_read) begin
                    ram_addr_next_s = avs_address;
                    ram_we_next_s   = 1'b0;
                end else begin
                    ram_we_next_s   = 1'b0;
                end
            end
            WR:      ram_we_next_s = 1'b0;
            RD_ADDR: ram_we_next_s = 1'b0;
            RD_DATA: begin
                readdata_next_s = ram_q;
                rdvalid_next_s  = 1'b1;
            end
            CLEAR: begin
                // The sweep counter mirrors the address presented this cycle
                if (cnt_r == LAST_ADDR) begin
                    done_next_s   = 1'b1;
                    ram_we_next_s = 1'b0;
                end else begin
                    cnt_next_s      = cnt_r + ADDR_ONE;
                    ram_addr_next_s = cnt_r + ADDR_ONE;
                    ram_data_next_s = fill_r;
                    ram_we_next_s   = 1'b1;
                end
            end
            default: ram_we_next_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ram_avalon_bridge.sv
// Bench for ram_avalon_bridge: a RAM model on the RAM port, an array of
// expected contents, and one task per scenario with inline comparisons.
module tb_ram_avalon_bridge;
    localparam int WORDS = 64;

    logic       clk, reset, avs_read, avs_write, clear_start;
    logic [5:0] avs_address, ram_addr;
    logic [7:0] avs_writedata, fill_value, ram_q, avs_readdata, ram_data;
    logic       avs_waitrequest, avs_readdatavalid, busy, clear_done, ram_we;

    logic [7:0] mem [WORDS];
    logic [7:0] ref_mem [WORDS];
    int checks = 0;
    int errors = 0;

    ram_avalon_bridge #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .clear_start(clear_start), .fill_value(fill_value), .busy(busy),
        .clear_done(clear_done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_data(ram_data), .ram_q(ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM: registered read, write on the clock edge
    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        int n;
        n = 0;
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge clk);
        while (avs_waitrequest && n < 200) begin tick(); @(negedge clk); n++; end
        checks++;
        if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_accept addr=%0d got wait=%b want 0", a, avs_waitrequest); end
        tick(); avs_write = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_we, ram_addr, ram_data} !== {1'b1, a, d}) begin
            errors++; $display("FAIL wr_cycle got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", ram_we, ram_addr, ram_data, a, d);
        end
        ref_mem[a] = d;
        tick(); @(negedge clk);
        checks++;
        if ({ram_we, avs_waitrequest} !== 2'b00) begin errors++; $display("FAIL wr_end got we=%b wait=%b want 0 0", ram_we, avs_waitrequest); end
        tick();
    endtask

    task automatic do_read(input logic [5:0] a);
        int n, lat, pulses;
        logic [7:0] got;
        n = 0; lat = 0; pulses = 0; got = 8'h00;
        avs_read = 1'b1; avs_address = a;
        @(negedge clk);
        while (avs_waitrequest && n < 200) begin tick(); @(negedge clk); n++; end
        checks++;
        if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_accept addr=%0d got wait=%b want 0", a, avs_waitrequest); end
        tick(); avs_read = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (avs_readdatavalid === 1'b1) begin
                pulses++;
                if (lat == 0) begin lat = k; got = avs_readdata; end
            end
            tick();
        end
        checks++;
        if (lat != 3 || pulses != 1) begin errors++; $display("FAIL rd_latency addr=%0d got lat=%0d pulses=%0d want lat=3 pulses=1", a, lat, pulses); end
        checks++;
        if (got !== ref_mem[a]) begin errors++; $display("FAIL rd_data addr=%0d got %h want %h", a, got, ref_mem[a]); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        checks++;
        if ({ram_addr, ram_we, ram_data, avs_readdata, avs_readdatavalid, clear_done, busy, avs_waitrequest}
            !== {6'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_values got addr=%0d we=%b data=%h rd=%h rdv=%b done=%b busy=%b wait=%b", ram_addr, ram_we, ram_data, avs_readdata, avs_readdatavalid, clear_done, busy, avs_waitrequest);
        end
        tick(); reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({avs_waitrequest, busy} !== 2'b00) begin errors++; $display("FAIL reset_release got wait=%b busy=%b want 0 0", avs_waitrequest, busy); end
        tick();
    endtask

    task automatic test_basic();
        do_write(6'd5, 8'hA5);
        do_read(6'd5);
    endtask

    task automatic test_back_to_back();
        int nacc, nrdv;
        int acc_c [2];
        int rdv_c [2];
        logic [7:0] rdv_d [2];
        nacc = 0; nrdv = 0;
        acc_c[0] = -1; acc_c[1] = -1; rdv_c[0] = -1; rdv_c[1] = -1; rdv_d[0] = 8'h00; rdv_d[1] = 8'h00;
        do_write(6'd0, 8'h11);
        do_write(6'd63, 8'h3F);
        avs_read = 1'b1; avs_address = 6'd63;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (avs_readdatavalid === 1'b1) begin
                if (nrdv < 2) begin rdv_c[nrdv] = c; rdv_d[nrdv] = avs_readdata; end
                nrdv++;
            end
            if (avs_read && avs_waitrequest === 1'b0) begin
                if (nacc < 2) acc_c[nacc] = c;
                nacc++;
            end
            tick();
            if (nacc == 1) avs_address = 6'd0;
            else if (nacc >= 2) avs_read = 1'b0;
        end
        checks++;
        if (nacc != 2 || acc_c[1] - acc_c[0] != 3) begin errors++; $display("FAIL b2b_accept got n=%0d at %0d,%0d want 2 reads 3 apart", nacc, acc_c[0], acc_c[1]); end
        checks++;
        if (nrdv != 2 || rdv_c[0] != acc_c[0] + 3 || rdv_c[1] != acc_c[1] + 3) begin
            errors++; $display("FAIL b2b_valid got n=%0d at %0d,%0d want 2 at accept+3", nrdv, rdv_c[0], rdv_c[1]);
        end
        checks++;
        if (rdv_d[0] !== ref_mem[63] || rdv_d[1] !== ref_mem[0]) begin
            errors++; $display("FAIL b2b_data got %h,%h want %h,%h", rdv_d[0], rdv_d[1], ref_mem[63], ref_mem[0]);
        end
    endtask

    task automatic test_random();
        logic [5:0] a;
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            a = 6'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) do_write(a, d);
            else do_read(a);
        end
    endtask

    task automatic test_clear();
        int we_cnt, first_we, last_we, bad, done_cnt, done_c, acc_c, rdv_c, busy_low;
        logic [7:0] rdv_d;
        we_cnt = 0; first_we = -1; last_we = -1; bad = 0; done_cnt = 0; done_c = -1;
        acc_c = -1; rdv_c = -1; busy_low = 0; rdv_d = 8'hEE;
        do_write(6'd10, 8'hC3);
        clear_start = 1'b1; fill_value = 8'h00;
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL clr_start_wait got %b want 1", avs_waitrequest); end
        tick(); clear_start = 1'b0; fill_value = 8'hFF; avs_read = 1'b1; avs_address = 6'd10;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                if (first_we < 0) first_we = c;
                last_we = c;
                if (ram_addr !== we_cnt[5:0] || ram_data !== 8'h00) bad++;
                we_cnt++;
            end
            if (clear_done === 1'b1) begin done_cnt++; done_c = c; end
            if (c <= 64 && busy !== 1'b1) busy_low++;
            if (avs_readdatavalid === 1'b1) begin rdv_c = c; rdv_d = avs_readdata; end
            if (avs_read && avs_waitrequest === 1'b0 && acc_c < 0) acc_c = c;
            tick();
            if (acc_c > 0) avs_read = 1'b0;
        end
        checks++;
        if (we_cnt != 64 || first_we != 1 || last_we != 64 || bad != 0) begin
            errors++; $display("FAIL clr_sweep got cnt=%0d first=%0d last=%0d bad=%0d want 64 1 64 0", we_cnt, first_we, last_we, bad);
        end
        checks++;
        if (done_cnt != 1 || done_c != 65) begin errors++; $display("FAIL clr_done got n=%0d at %0d want 1 at 65", done_cnt, done_c); end
        checks++;
        if (busy_low != 0) begin errors++; $display("FAIL clr_busy got low_cycles=%0d want 0", busy_low); end
        checks++;
        if (acc_c != 65 || rdv_c != 68 || rdv_d !== 8'h00) begin
            errors++; $display("FAIL clr_held_read got acc=%0d rdv=%0d data=%h want 65 68 00", acc_c, rdv_c, rdv_d);
        end
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < WORDS; i++) do_read(6'(i));
    endtask

    task automatic test_clear_vs_write();
        logic [5:0] a;
        logic [7:0] d, f;
        int done_c, acc_c;
        logic [14:0] wr_seen;
        a = 6'($urandom); d = 8'($urandom); f = 8'($urandom_range(1, 255));
        done_c = -1; acc_c = -1; wr_seen = 15'd0;
        clear_start = 1'b1; fill_value = f; avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL cw_wait got %b want 1", avs_waitrequest); end
        tick(); clear_start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (clear_done === 1'b1) done_c = c;
            if (acc_c > 0 && c == acc_c + 1) wr_seen = {ram_we, ram_addr, ram_data};
            if (avs_write && avs_waitrequest === 1'b0 && acc_c < 0) acc_c = c;
            tick();
            if (acc_c > 0) avs_write = 1'b0;
        end
        checks++;
        if (done_c != 65 || acc_c != 65) begin errors++; $display("FAIL cw_order got done=%0d acc=%0d want 65 65", done_c, acc_c); end
        checks++;
        if (wr_seen !== {1'b1, a, d}) begin errors++; $display("FAIL cw_write got %h want %h", wr_seen, {1'b1, a, d}); end
        for (int i = 0; i < WORDS; i++) ref_mem[i] = f;
        ref_mem[a] = d;
        do_read(a);
        do_read(a + 6'd1);
    endtask

    task automatic test_rw_both();
        int pulses;
        logic [14:0] wr_seen;
        pulses = 0; wr_seen = 15'd0;
        avs_read = 1'b1; avs_write = 1'b1; avs_address = 6'd7; avs_writedata = 8'h5A;
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL both_accept got wait=%b want 0", avs_waitrequest); end
        tick(); avs_read = 1'b0; avs_write = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) wr_seen = {ram_we, ram_addr, ram_data};
            if (avs_readdatavalid === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL both_no_valid got %0d pulses want 0", pulses); end
        checks++;
        if (wr_seen !== {1'b1, 6'd7, 8'h5A}) begin errors++; $display("FAIL both_write got %h want %h", wr_seen, {1'b1, 6'd7, 8'h5A}); end
        ref_mem[7] = 8'h5A;
        do_read(6'd7);
    endtask

    task automatic test_reset_read();
        int pulses;
        pulses = 0;
        do_write(6'd30, 8'($urandom));
        avs_read = 1'b1; avs_address = 6'd30;
        @(negedge clk);
        tick(); avs_read = 1'b0; reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rr_in_rdaddr got busy=%b want 1", busy); end
        tick(); reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_we, busy, avs_waitrequest, avs_readdatavalid} !== 4'b0000) begin
            errors++; $display("FAIL rr_after got we=%b busy=%b wait=%b rdv=%b want 0000", ram_we, busy, avs_waitrequest, avs_readdatavalid);
        end
        for (int c = 0; c < 6; c++) begin
            if (avs_readdatavalid === 1'b1) pulses++;
            tick(); @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rr_no_valid got %0d pulses want 0", pulses); end
        tick();
        do_read(6'd30);
    endtask

    task automatic test_reset_clear();
        logic [7:0] f;
        int dones, wes;
        f = 8'($urandom_range(1, 255)); dones = 0; wes = 0;
        clear_start = 1'b1; fill_value = f;
        tick(); clear_start = 1'b0;
        for (int c = 1; c < 21; c++) tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_we, ram_addr} !== {1'b1, 6'd20}) begin errors++; $display("FAIL rc_at20 got we=%b addr=%0d want 1 20", ram_we, ram_addr); end
        tick(); reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_we, busy, avs_waitrequest, clear_done} !== 4'b0000) begin
            errors++; $display("FAIL rc_after got we=%b busy=%b wait=%b done=%b want 0000", ram_we, busy, avs_waitrequest, clear_done);
        end
        for (int c = 0; c < 70; c++) begin
            if (clear_done === 1'b1) dones++;
            if (ram_we === 1'b1) wes++;
            tick(); @(negedge clk);
        end
        checks++;
        if (dones != 0 || wes != 0) begin errors++; $display("FAIL rc_abandon got done=%0d we=%0d want 0 0", dones, wes); end
        tick();
        for (int i = 0; i <= 20; i++) ref_mem[i] = f;
        do_read(6'd0);
        do_read(6'd20);
        do_read(6'd21);
    endtask

    initial begin
        reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0; clear_start = 1'b0;
        avs_address = 6'd0; avs_writedata = 8'h00; fill_value = 8'h00;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_clear();
        test_clear_vs_write();
        test_rw_both();
        test_reset_read();
        test_reset_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
